// File: rtl/uart16550_wb_ctrl.sv
// Wishbone master sequencer for one 16550-style UART: programs divisor/LCR/IER,
// then polls LSR and shares the bus round-robin between THR writes and RB reads.
module uart16550_wb_ctrl #(
    parameter int ACK_TIMEOUT   = 255,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [15:0] cfg_div,
    input  logic [7:0]  cfg_lcr,
    input  logic [7:0]  cfg_ie,
    output logic        cfg_done,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [3:0]  err_sticky,
    output logic        timeout,
    input  logic        err_clr,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic [2:0]  dbg_state_o
);

    localparam int CW = $clog2(TX_FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(TX_FIFO_DEPTH);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [4:0] A_DATA = 5'd0;
    localparam logic [4:0] A_IER  = 5'd1;
    localparam logic [4:0] A_LCR  = 5'd3;
    localparam logic [4:0] A_LSR  = 5'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_POLL  = 3'd2,
        S_TX_WR = 3'd3,
        S_RX_RD = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     cfg_idx_q, cfg_idx_d;
    logic           cfg_done_q, cfg_done_d;
    logic           cfg_pend_q, cfg_pend_d;
    logic           cyc_q, cyc_d;
    logic           we_q, we_d;
    logic [4:0]     adr_q, adr_d;
    logic [3:0]     sel_q, sel_d;
    logic [31:0]    dat_q, dat_d;
    logic [7:0]     tmo_cnt_q, tmo_cnt_d;
    logic           gap_q, gap_d;
    logic [CW-1:0]  credit_q, credit_d;
    logic           last_tx_q, last_tx_d;
    logic           tx_ready_q, tx_ready_d;
    logic           rx_valid_q, rx_valid_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic [3:0]     err_q, err_d;
    logic           timeout_q, timeout_d;

    logic           iss_en, iss_we;
    logic [4:0]     iss_adr;
    logic [7:0]     iss_byte;
    logic [7:0]     rd_byte;
    logic [CW-1:0]  credit_eff;
    logic           tx_elig, rx_elig;
    logic           ack_hit, tmo_hit;
    logic           unused_lcr7;

    assign unused_lcr7 = cfg_lcr[7];
    assign ack_hit = cyc_q && wb_ack_i;
    assign tmo_hit = cyc_q && !wb_ack_i && (tmo_cnt_q == TMO_LAST);
    assign rd_byte = wb_dat_i[{adr_q[1:0], 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cfg_idx_q  <= '0;
            cfg_done_q <= 1'b0;
            cfg_pend_q <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            sel_q      <= '0;
            dat_q      <= '0;
            tmo_cnt_q  <= '0;
            gap_q      <= 1'b0;
            credit_q   <= '0;
            last_tx_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            err_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_idx_q  <= cfg_idx_d;
            cfg_done_q <= cfg_done_d;
            cfg_pend_q <= cfg_pend_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            sel_q      <= sel_d;
            dat_q      <= dat_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_q      <= gap_d;
            credit_q   <= credit_d;
            last_tx_q  <= last_tx_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_idx_d  = cfg_idx_q;
        cfg_done_d = cfg_done_q;
        cfg_pend_d = cfg_pend_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        dat_d      = dat_q;
        tmo_cnt_d  = tmo_cnt_q;
        gap_d      = 1'b0;
        credit_d   = credit_q;
        last_tx_d  = last_tx_q;
        tx_ready_d = 1'b0;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        err_d      = err_q;
        timeout_d  = timeout_q;
        iss_en     = 1'b0;
        iss_we     = 1'b0;
        iss_adr    = '0;
        iss_byte   = '0;
        credit_eff = credit_q;
        tx_elig    = 1'b0;
        rx_elig    = 1'b0;

        if (cfg_start) cfg_pend_d = 1'b1;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (cyc_q && !wb_ack_i) tmo_cnt_d = tmo_cnt_q + 8'd1;

        // Ack or timeout ends the bus cycle; gap_q forces one extra idle cycle.
        if (ack_hit || tmo_hit) begin
            cyc_d     = 1'b0;
            we_d      = 1'b0;
            adr_d     = '0;
            sel_d     = '0;
            dat_d     = '0;
            tmo_cnt_d = '0;
            gap_d     = 1'b1;
        end
        if (tmo_hit) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start || cfg_pend_q) begin
                    state_d    = S_CFG;
                    cfg_done_d = 1'b0;
                    cfg_idx_d  = '0;
                    cfg_pend_d = 1'b0;
                end else if (cfg_done_q) begin
                    state_d = S_POLL;
                end
            end
            S_CFG: begin
                if (cfg_idx_q == 3'd5) begin
                    cfg_done_d = 1'b1;
                    credit_d   = CREDIT_FULL;
                    state_d    = S_IDLE;
                end else if (!cyc_q && !gap_q) begin
                    iss_en = 1'b1;
                    iss_we = 1'b1;
                    case (cfg_idx_q)
                        3'd0:    begin iss_adr = A_LCR;  iss_byte = {1'b1, cfg_lcr[6:0]}; end
                        3'd1:    begin iss_adr = A_DATA; iss_byte = cfg_div[7:0];         end
                        3'd2:    begin iss_adr = A_IER;  iss_byte = cfg_div[15:8];        end
                        3'd3:    begin iss_adr = A_LCR;  iss_byte = {1'b0, cfg_lcr[6:0]}; end
                        default: begin iss_adr = A_IER;  iss_byte = cfg_ie;               end
                    endcase
                end
                if (ack_hit) cfg_idx_d = cfg_idx_q + 3'd1;
            end
            S_POLL: begin
                if (!cyc_q && !gap_q) begin
                    iss_en  = 1'b1;
                    iss_adr = A_LSR;
                end
                if (ack_hit) begin
                    err_d = err_q | rd_byte[4:1];
                    if (rd_byte[5]) credit_eff = CREDIT_FULL;
                    credit_d = credit_eff;
                    tx_elig  = tx_valid && (credit_eff != '0);
                    rx_elig  = rd_byte[0] && !rx_valid_q;
                    // On a tie the side not granted last time wins.
                    if (tx_elig && (!rx_elig || !last_tx_q)) begin
                        state_d   = S_TX_WR;
                        last_tx_d = 1'b1;
                    end else if (rx_elig) begin
                        state_d   = S_RX_RD;
                        last_tx_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_TX_WR: begin
                if (!cyc_q && !gap_q) begin
                    iss_en     = 1'b1;
                    iss_we     = 1'b1;
                    iss_adr    = A_DATA;
                    iss_byte   = tx_data;
                    tx_ready_d = 1'b1;
                end
                if (ack_hit) begin
                    if (credit_q != '0) credit_d = credit_q - CW'(1);
                    state_d = S_IDLE;
                end
            end
            S_RX_RD: begin
                if (!cyc_q && !gap_q) begin
                    iss_en  = 1'b1;
                    iss_adr = A_DATA;
                end
                if (ack_hit) begin
                    rx_data_d  = rd_byte;
                    rx_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (iss_en) begin
            cyc_d     = 1'b1;
            we_d      = iss_we;
            adr_d     = iss_adr;
            sel_d     = 4'b0001 << iss_adr[1:0];
            dat_d     = {24'h0, iss_byte} << {iss_adr[1:0], 3'b000};
            tmo_cnt_d = '0;
        end

        if (err_clr) begin
            err_d     = '0;
            timeout_d = 1'b0;
        end
    end

    assign cfg_done    = cfg_done_q;
    assign tx_ready    = tx_ready_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign err_sticky  = err_q;
    assign timeout     = timeout_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign wb_stb_o    = cyc_q;
    assign wb_cyc_o    = cyc_q;
    assign dbg_state_o = state_q;

endmodule
